// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encoding,
// a constant-function clog2 and the default Tx_Busy rise timeout.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEFAULT_BUSY_TIMEOUT = 16;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: starting at the pointer and
// searching upward with wrap, the first asserted request wins.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    // Rotate the requests so the pointer position lands at bit 0.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    // Lowest set bit of the rotated vector, then map back to a requester index.
    always_comb begin
        o_any = |i_req;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
        end
        o_winner = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. A round-robin
// winner's byte is latched into Data_to_send, Tx_Start is pulsed, and the FSM
// follows Tx_Busy until the frame ends (or times out if it never rises).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           Data_to_send,
    output logic                 Tx_Start,
    input  logic                 Tx_Busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam int TMR_W = clog2(BUSY_TIMEOUT + 1);

    arb_state_t         r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [TMR_W-1:0]   r_timer;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [7:0]         r_data;
    logic               r_tx_start;
    logic [ID_W-1:0]    r_grant;
    logic               r_arb_busy;
    logic               r_timeout;

    logic [ID_W-1:0]    w_winner;
    logic               w_any;
    logic [7:0]         w_byte;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Select the winning requester's byte from the packed data bus.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_byte = req_data[8*k +: 8];
            end
        end
    end

    // Sequencing FSM; every output is registered so pulses are glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_timer     <= '0;
            r_req_ready <= '0;
            r_data      <= '0;
            r_tx_start  <= 1'b0;
            r_grant     <= '0;
            r_arb_busy  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_tx_start  <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // An externally busy tx blocks grants entirely.
                    if (!Tx_Busy && w_any) begin
                        r_req_ready <= NUM_REQ'(1) << w_winner;
                        r_data      <= w_byte;
                        r_grant     <= w_winner;
                        r_ptr       <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                        r_arb_busy  <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_tx_start <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Tx_Busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        // tx never acknowledged: the byte is dropped.
                        r_timeout  <= 1'b1;
                        r_arb_busy <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_Busy) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_arb_busy <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign Data_to_send = r_data;
    assign Tx_Start     = r_tx_start;
    assign grant_id     = r_grant;
    assign arb_busy     = r_arb_busy;
    assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural tx: Tx_Busy rises one
// cycle after Tx_Start and stays high for 10 cycles.
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  Data_to_send;
    logic        Tx_Start;
    logic        Tx_Busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    logic model_busy = 1'b0;
    int   model_cnt  = 0;
    logic tx_en      = 1'b1;
    logic ext_busy   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .ID_W         (2),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .Data_to_send (Data_to_send),
        .Tx_Start     (Tx_Start),
        .Tx_Busy      (Tx_Busy),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    assign Tx_Busy = ext_busy | model_busy;

    // Behavioural transmitter; ignores the arbiter's reset.
    always @(posedge clock) begin
        if (model_busy) begin
            if (model_cnt == 1) model_busy <= 1'b0;
            model_cnt <= model_cnt - 1;
        end else if (tx_en && Tx_Start) begin
            model_busy <= 1'b1;
            model_cnt  <= 10;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (req_ready == 4'b0 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while ((arb_busy || Tx_Busy) && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        req_valid = '0;
        req_data  = '0;
        do_reset();
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_vec++; if (Data_to_send !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", Data_to_send); end
        n_vec++; if (Tx_Start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", Tx_Start); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_vec++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    endtask

    task automatic test_single();
        int cyc;
        int bad;
        int starts;
        req_data[7:0] = 8'hAA;
        req_valid = 4'b0001;
        tick();
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_vec++; if (Data_to_send !== 8'hAA) begin n_err++; $display("FAIL single_data: got %h want aa", Data_to_send); end
        n_vec++; if (Tx_Start !== 1'b0) begin n_err++; $display("FAIL single_start_early: got %b want 0", Tx_Start); end
        n_vec++; if (arb_busy !== 1'b1) begin n_err++; $display("FAIL single_arb_busy: got %b want 1", arb_busy); end
        req_valid = 4'b0000;
        tick();
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
        n_vec++; if (Tx_Start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", Tx_Start); end
        tick();
        n_vec++; if (Tx_Start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b want 0", Tx_Start); end
        bad = 0; starts = 0; cyc = 0;
        while (arb_busy && cyc < 40) begin
            if (Data_to_send !== 8'hAA) bad++;
            if (Tx_Start) starts++;
            tick();
            cyc++;
        end
        n_vec++; if (cyc >= 40) begin n_err++; $display("FAIL single_frame_end: got %0d cycles want <40", cyc); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL single_data_stable: got %0d changes want 0", bad); end
        n_vec++; if (starts !== 0) begin n_err++; $display("FAIL single_extra_start: got %0d want 0", starts); end
        n_vec++; if (Data_to_send !== 8'hAA) begin n_err++; $display("FAIL single_data_after: got %h want aa", Data_to_send); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int starts;
        int exp_id;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        starts = 0;
        for (int f = 0; f < 5; f++) begin
            exp_id = f % 4;
            cyc = 0;
            while (req_ready == 4'b0 && cyc < 40) begin
                if (Tx_Start) starts++;
                tick();
                cyc++;
            end
            n_vec++; if (cyc >= 40) begin n_err++; $display("FAIL rr_grant_wait f%0d: got no grant want grant", f); end
            if (f > 0) begin
                n_vec++; if (starts !== 1) begin n_err++; $display("FAIL rr_starts f%0d: got %0d want 1", f, starts); end
            end
            starts = 0;
            n_vec++; if (req_ready !== (4'b0001 << exp_id)) begin n_err++; $display("FAIL rr_ready f%0d: got %b want %b", f, req_ready, 4'b0001 << exp_id); end
            n_vec++; if (grant_id !== 2'(exp_id)) begin n_err++; $display("FAIL rr_grant f%0d: got %0d want %0d", f, grant_id, exp_id); end
            n_vec++; if (Data_to_send !== 8'(8'h10 + exp_id)) begin n_err++; $display("FAIL rr_data f%0d: got %h want %h", f, Data_to_send, 8'(8'h10 + exp_id)); end
            tick();
        end
        req_valid = 4'b0000;
        cyc = 0;
        while ((arb_busy || Tx_Busy) && cyc < 60) begin
            if (Tx_Start) starts++;
            tick();
            cyc++;
        end
        n_vec++; if (starts !== 1) begin n_err++; $display("FAIL rr_last_starts: got %0d want 1", starts); end
    endtask

    task automatic test_pointer();
        int cyc;
        do_reset();
        req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        req_valid = 4'b0100;
        wait_ready(cyc);
        n_vec++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin n_err++; $display("FAIL ptr_first: got id %0d ready %b want id 2 ready 0100", grant_id, req_ready); end
        req_valid = 4'b1100;
        tick();
        wait_ready(cyc);
        n_vec++; if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin n_err++; $display("FAIL ptr_second: got id %0d ready %b want id 3 ready 1000", grant_id, req_ready); end
        n_vec++; if (Data_to_send !== 8'h33) begin n_err++; $display("FAIL ptr_second_data: got %h want 33", Data_to_send); end
        tick();
        wait_ready(cyc);
        n_vec++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin n_err++; $display("FAIL ptr_third: got id %0d ready %b want id 2 ready 0100", grant_id, req_ready); end
        n_vec++; if (Data_to_send !== 8'h22) begin n_err++; $display("FAIL ptr_third_data: got %h want 22", Data_to_send); end
        req_valid = 4'b0000;
        tick();
        wait_idle(cyc);
    endtask

    task automatic test_timeout();
        int cyc;
        int n;
        int starts;
        tx_en = 1'b0;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        wait_ready(cyc);
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL to_ready: got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        tick();
        n_vec++; if (Tx_Start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b want 1", Tx_Start); end
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        n_vec++; if (n !== 16) begin n_err++; $display("FAIL to_latency: got %0d cycles want 16", n); end
        n_vec++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL to_idle: got arb_busy %b want 0", arb_busy); end
        tick();
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pulse: got %b want 0", timeout_err); end
        tx_en = 1'b1;
        req_data[15:8] = 8'h66;
        req_valid = 4'b0010;
        wait_ready(cyc);
        n_vec++; if (req_ready !== 4'b0010 || Data_to_send !== 8'h66) begin n_err++; $display("FAIL to_next_grant: got ready %b data %h want 0010 66", req_ready, Data_to_send); end
        req_valid = 4'b0000;
        starts = 0; cyc = 0;
        tick();
        while ((arb_busy || Tx_Busy) && cyc < 60) begin
            if (Tx_Start) starts++;
            if (timeout_err) starts = starts + 100;
            tick();
            cyc++;
        end
        n_vec++; if (starts !== 1) begin n_err++; $display("FAIL to_next_frame: got code %0d want 1", starts); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        req_data[7:0] = 8'h77;
        req_valid = 4'b0001;
        wait_ready(cyc);
        req_valid = 4'b0000;
        cyc = 0;
        while (!Tx_Busy && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++; if (Tx_Busy !== 1'b1) begin n_err++; $display("FAIL rm_busy_rise: got %b want 1", Tx_Busy); end
        tick();
        tick();
        reset = 1'b1;
        req_data[15:8] = 8'h88;
        req_valid = 4'b0011;
        tick();
        n_vec++; if (req_ready !== 4'b0 || Tx_Start !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rm_pulses: got ready %b start %b to %b want 0", req_ready, Tx_Start, timeout_err); end
        n_vec++; if (Data_to_send !== 8'h00) begin n_err++; $display("FAIL rm_data: got %h want 00", Data_to_send); end
        n_vec++; if (grant_id !== 2'd0 || arb_busy !== 1'b0) begin n_err++; $display("FAIL rm_state: got id %0d busy %b want 0 0", grant_id, arb_busy); end
        reset = 1'b0;
        bad = 0; cyc = 0;
        while (Tx_Busy && cyc < 40) begin
            if (req_ready !== 4'b0 || Tx_Start) bad++;
            tick();
            cyc++;
        end
        n_vec++; if (bad !== 0 || cyc >= 40) begin n_err++; $display("FAIL rm_hold_off: got %0d early grants, %0d cycles want 0 and <40", bad, cyc); end
        tick();
        n_vec++; if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin n_err++; $display("FAIL rm_ptr_reset: got ready %b id %0d want 0001 0", req_ready, grant_id); end
        n_vec++; if (Data_to_send !== 8'h77) begin n_err++; $display("FAIL rm_data_after: got %h want 77", Data_to_send); end
        req_valid = 4'b0000;
        tick();
        wait_idle(cyc);
    endtask

    task automatic test_ext_busy();
        int cyc;
        int bad;
        ext_busy = 1'b1;
        req_data[7:0] = 8'h99;
        req_valid = 4'b0001;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req_ready !== 4'b0 || arb_busy) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL eb_blocked: got %0d grants want 0", bad); end
        ext_busy = 1'b0;
        tick();
        n_vec++; if (req_ready !== 4'b0001 || Data_to_send !== 8'h99) begin n_err++; $display("FAIL eb_release: got ready %b data %h want 0001 99", req_ready, Data_to_send); end
        req_valid = 4'b0000;
        tick();
        wait_idle(cyc);
        ext_busy = 1'b1;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        req_valid = 4'b0000;
        tick();
        ext_busy = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready !== 4'b0 || Tx_Start || arb_busy) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL eb_dropped: got %0d activity cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer();
        test_timeout();
        test_reset_mid();
        test_ext_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1);
    end

endmodule
